parallel_byte_rx: RTL and testbench

Receiver for the 8-bit parallel byte link driven by the board-level streaming interface. The sender places a byte on an 8-bit bus and raises a trigger line for each byte. A message ends with a 0x00 terminator. This block synchronizes the asynchronous trigger, captures each byte into a FIFO and frames messages on the terminator. It sits between the Arduino header pins and any consumer logic, such as the CPU data-memory path or a display driver, that drains the FIFO.

---
 rtl/parallel_byte_rx_if.sv | 16 +
 rtl/parallel_byte_rx.sv | 107 ++++++++++
 tb/tb_parallel_byte_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_byte_rx_if.sv
// Byte link from the sender plus the FIFO read port toward the consumer.
// master = environment (sender and consumer), slave = receiver.
interface parallel_byte_rx_if #(parameter int DEPTH = 16);
  logic [7:0]             rx_data;
  logic                   rx_strobe;
  logic                   rd_en;
  logic [7:0]             rd_data;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;

  modport master (output rx_data, rx_strobe, rd_en,
                  input  rd_data, empty, full, count);
  modport slave  (input  rx_data, rx_strobe, rd_en,
                  output rd_data, empty, full, count);
endinterface

// File: rtl/parallel_byte_rx.sv
// Parallel byte link receiver: synchronizes the async strobe, stores bytes in a
// FIFO and frames messages on the terminator byte.
module parallel_byte_rx #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] TERM  = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  parallel_byte_rx_if.slave  bus,
  input  logic               rearm,
  output logic               busy,
  output logic               msg_done,
  output logic               byte_pulse,
  output logic               overflow,
  output logic [15:0]        rx_bytes
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  state_t state;

  logic          s1, s2, s3;
  logic [7:0]    d1, d2;
  logic          strobe_edge, store, push, pop, is_full;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [DEPTH];

  // Data rides one flop pair alongside the strobe so d2 is stable when the edge fires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      {s1, s2, s3} <= {bus.rx_strobe, s1, s2};
      d1 <= bus.rx_data;
      d2 <= d1;
    end
  end

  assign strobe_edge = s2 & ~s3;
  assign is_full     = (count == CW'(DEPTH));
  assign store       = strobe_edge & ~rearm & (state != DONE) & (d2 != TERM);
  assign push        = store & ~is_full;
  assign pop         = bus.rd_en & (count != '0);

  assign bus.count = count;
  assign bus.empty = (count == '0);
  assign bus.full  = is_full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        bus.rd_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Framing FSM; rearm wins over a coincident edge, which is then lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      msg_done   <= 1'b0;
      overflow   <= 1'b0;
      byte_pulse <= 1'b0;
      rx_bytes   <= '0;
    end else begin
      byte_pulse <= push;
      if (push) rx_bytes <= rx_bytes + 16'd1;
      if (rearm) begin
        state    <= IDLE;
        busy     <= 1'b0;
        msg_done <= 1'b0;
        overflow <= 1'b0;
      end else if (strobe_edge && state != DONE) begin
        if (d2 == TERM) begin
          state    <= DONE;
          busy     <= 1'b0;
          msg_done <= 1'b1;
        end else begin
          state <= RECV;
          busy  <= 1'b1;
          if (is_full) overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_parallel_byte_rx.sv
// Scoreboard bench for parallel_byte_rx: a message-level model predicts stored
// bytes and status; a monitor checks every accepted pop against the queue.
module tb_parallel_byte_rx;
  localparam int         DEPTH = 16;
  localparam logic [7:0] TERM  = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rearm = 1'b0;
  logic        busy, msg_done, byte_pulse, overflow;
  logic [15:0] rx_bytes;

  parallel_byte_rx_if #(.DEPTH(DEPTH)) bus();

  parallel_byte_rx #(.DEPTH(DEPTH), .TERM(TERM)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rearm(rearm),
    .busy(busy), .msg_done(msg_done), .byte_pulse(byte_pulse),
    .overflow(overflow), .rx_bytes(rx_bytes)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: 0 = idle, 1 = mid-message, 2 = terminator seen
  int          m_st = 0;
  logic [7:0]  exp_q[$];
  bit          m_ovf = 0;
  logic [15:0] m_rxb = 0;
  int          m_pulses = 0;
  int          obs_pulses = 0;
  logic [7:0]  last_rd = 0;
  bit          pend_pop = 0, pend_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    pend_pop  = !rst && bus.rd_en && exp_q.size() != 0;
    pend_hold = !rst && bus.rd_en && exp_q.size() == 0;
  end

  always @(posedge clk) begin
    #1;
    if (byte_pulse === 1'b1) obs_pulses++;
    if (pend_pop) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("pop_data", {24'd0, bus.rd_data}, {24'd0, e});
      last_rd = e;
    end else if (pend_hold) begin
      check("rd_hold", {24'd0, bus.rd_data}, {24'd0, last_rd});
    end
  end

  task automatic send(input logic [7:0] b, input bit pop_at_store = 1'b0);
    @(negedge clk) bus.rx_data = b;
    @(negedge clk) bus.rx_strobe = 1'b1;
    if (m_st != 2) begin
      if (b == TERM) m_st = 2;
      else begin
        m_st = 1;
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(b);
          m_rxb = m_rxb + 16'd1;
          m_pulses++;
        end else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    @(negedge clk) if (pop_at_store) bus.rd_en = 1'b1;
    @(negedge clk) begin
      bus.rd_en = 1'b0;
      bus.rx_strobe = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_n(input int n);
    if (n > 0) begin
      @(negedge clk) bus.rd_en = 1'b1;
      repeat (n) @(negedge clk);
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic do_rearm();
    @(negedge clk) rearm = 1'b1;
    @(negedge clk) rearm = 1'b0;
    m_st = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_count"},    32'(bus.count), exp_q.size());
    check({tag, "_empty"},    32'(bus.empty), 32'(exp_q.size() == 0));
    check({tag, "_full"},     32'(bus.full),  32'(exp_q.size() == DEPTH));
    check({tag, "_overflow"}, 32'(overflow),  32'(m_ovf));
    check({tag, "_rx_bytes"}, 32'(rx_bytes),  32'(m_rxb));
    check({tag, "_msg_done"}, 32'(msg_done),  32'(m_st == 2));
    check({tag, "_busy"},     32'(busy),      32'(m_st == 1));
    check({tag, "_pulses"},   obs_pulses,     m_pulses);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_count",    32'(bus.count),   0);
    check("rst_empty",    32'(bus.empty),   1);
    check("rst_full",     32'(bus.full),    0);
    check("rst_rd_data",  32'(bus.rd_data), 0);
    check("rst_busy",     32'(busy),        0);
    check("rst_msg_done", 32'(msg_done),    0);
    check("rst_pulse",    32'(byte_pulse),  0);
    check("rst_overflow", 32'(overflow),    0);
    check("rst_rx_bytes", 32'(rx_bytes),    0);
    exp_q.delete();
    m_st = 0; m_ovf = 1'b0; m_rxb = 0; last_rd = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] msg[9];
    msg = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h0A};
    bus.rx_data = 8'h00; bus.rx_strobe = 1'b0; bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // text message with embedded newline
    foreach (msg[i]) send(msg[i]);
    send(TERM);
    check_state("msg");
    pop_n(9);
    check_state("msg_drain");
    pop_n(2);
    do_rearm();
    check_state("rearm1");

    // overflow, then a store edge coinciding with a pop at full
    for (int i = 1; i <= 20; i++) send(8'(i));
    check_state("ovf");
    send(8'h15, 1'b1);
    check_state("full_pop");
    pop_n(15);
    check_state("ovf_drain");

    // terminator locks out further bytes until rearm
    send(TERM);
    send(8'h55);
    check_state("done_lock");
    do_rearm();
    check_state("rearm2");
    send(8'h55);
    check_state("after_rearm");
    pop_n(1);

    // reset mid-message discards the partial message
    send(8'h31); send(8'h32); send(8'h33);
    do_reset();
    send(8'h7A);
    send(TERM);
    check_state("post_rst");
    pop_n(1);
    check_state("post_rst_drain");

    // random messages with interleaved drain phases
    for (int r = 0; r < 6; r++) begin
      int len;
      do_rearm();
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) send(8'h0A);
        else send(8'($urandom_range(1, 255)));
      end
      if ($urandom_range(0, 1) == 1) send(TERM);
      check_state("rand_msg");
      pop_n($urandom_range(0, len + 2));
      check_state("rand_pop");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
